pll_clk_en_gen: RTL
===================

# pll_clk_en_gen

Parametrised clock-enable generator for the RX clocking path, placed directly after the PLL. It qualifies the PLL's raw `locked` output and derives `NUM_CH` independent, runtime-programmable clock-enable pulse trains from a single PLL output clock. This replaces fixed secondary PLL outputs such as the 1 MHz tick with synchronous enables. All channels are phase-aligned on lock and on every divider reload.

## Interface
- `NUM_CH`, 2, number of enable channels (1..16)
- `CNT_W`, 16, divider counter width per channel
- `LOCK_CYCLES`, 1024, consecutive synchronised-locked cycles required before release (≥1)
- `DIV_RST`, {NUM_CH{16'd48}}, reset value of the divider shadow registers, NUM_CH*CNT_W bits
- `refclk` in 1: the single clock, e.g. 48 MHz PLL `outclk_0`
- `rst_n` in 1: asynchronous active-low reset
- `pll_locked` in 1: raw PLL lock, asynchronous to `refclk`
- `div_i` in NUM_CH*CNT_W: new divide ratios; channel k occupies bits [k*CNT_W +: CNT_W]
- `div_load` in 1: single-cycle strobe that captures `div_i`
- `locked_q` out 1: qualified lock
- `ce` out NUM_CH: one-cycle enable pulses, one bit per channel
- `clk_out` out NUM_CH: toggled square outputs (only with the macro below)

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give `lk_s`.
- Lock FSM states:
  - UNLOCKED → QUALIFY when `lk_s`=1.
  - QUALIFY counts consecutive `lk_s`=1 cycles. It returns to UNLOCKED on any `lk_s`=0 and clears the count. It moves to LOCKED when the count reaches LOCKED_CYCLES.
  - LOCKED → UNLOCKED on `lk_s`=0, with no filtering on loss.
- `locked_q` = (state == LOCKED).
- Shadow dividers `div_r[k]` load from `div_i` when `div_load`=1, in any state.
- Per-channel counter `cnt[k]`, CNT_W bits:
  - Held at 0 outside LOCKED.
  - In LOCKED: `ce[k]`=1 when `cnt[k]` == `div_r[k]`-1; in that cycle `cnt[k]` wraps to 0, otherwise it increments.
- Divider value rules:
  - `div_r[k]`=0: channel disabled, `ce[k]`=0, counter held at 0.
  - `div_r[k]`=1: `ce[k]`=1 every LOCKED cycle.
- Reload alignment: `div_load` while LOCKED forces every counter to 0 in the next cycle, which restarts the phase on all channels together.
- Simultaneous events:
  - `div_load` together with loss of lock: loss wins, and the shadow still captures `div_i`.
  - `div_load` in the same cycle as a terminal count: no `ce` pulse is suppressed that cycle; realignment applies from the next cycle.

## Timing
- Reset values: state=UNLOCKED, `locked_q`=0, `ce`=0, `clk_out`=0, counters=0, `div_r`=DIV_RST, synchroniser=0.
- Lock latency: `pll_locked` rise → `locked_q` rise takes 2 + LOCK_CYCLES cycles (±1 for synchroniser metastability).
- Loss latency: `pll_locked` fall → `locked_q` = 0 and `ce` = 0 within 3 cycles.
- Let cycle 0 be the first cycle with `locked_q`=1. Then `ce[k]` first pulses in cycle div_r[k]-1, with period div_r[k].
- After a `div_load` in cycle t, the first `ce[k]` pulse is in cycle t+div_new[k].
- All outputs are registered.

## Configuration
- Macro: `PLL_CLK_EN_GEN_TOGGLE_EN`.
- Defined:
  - `clk_out[k]` toggles in every cycle where `ce[k]`=1, giving period 2·div_r[k] at 50% duty.
  - `clk_out[k]` is forced to 0 outside LOCKED and on reload.
- Undefined: the `clk_out` port still exists, is tied to 0, and no toggle flops are built.

## Structure
- Shared package `pll_clk_pkg` holds:
  - the lock FSM state enum (UNLOCKED, QUALIFY, LOCKED);
  - the lock-counter width function, clog2(LOCK_CYCLES+1).
- Sub-module `clk_en_div`: one channel (counter, terminal compare, optional toggle), instantiated NUM_CH times.
- The synchroniser is the team's standard 2-flop cell.

## Test plan
- Reset and lock: NUM_CH=2, LOCK_CYCLES=16, `pll_locked` rises → `locked_q` rises 18 (±1) cycles later, with `ce`=0 until then.
- Glitch rejection: `pll_locked` high for 10 cycles, low for 1, then high → qualification restarts and `locked_q` rises 18 (±1) cycles after the final rise.
- Divide ratios: `div_r`={48,1} → `ce[0]` pulses every 48 cycles with the first at cycle 47; `ce[1]` is high every cycle.
- Reload alignment: load {5,3} mid-run at cycle t → `ce[0]` at t+5, t+10…; `ce[1]` at t+3, t+6….
- Disable and lock loss: div=0 → `ce`=0. Drop `pll_locked` → `locked_q`=0 and all `ce`=0 within 3 cycles. Assert `rst_n`=0 mid-run → all outputs 0 immediately.
- With `PLL_CLK_EN_GEN_TOGGLE_EN`, div=4 → `clk_out` has period 8 cycles at 50% duty, starting from 0.

Source files
------------

// File: rtl/pll_clk_pkg.sv
// Shared types and helpers for the PLL clock-enable generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_clk_pkg;

    // Lock qualification states
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        QUALIFY  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_e;

    // Width of the qualification counter, wide enough to hold lock_cycles
    function automatic int lock_cnt_w(input int lock_cycles);
        return $clog2(lock_cycles + 1);
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// One clock-enable channel: counter, terminal compare, optional 50% toggle output.
// Latency: ce/clk_out registered, computed from the next-cycle lock state (no extra delay).
// Backpressure: none; free-running while run=1, held at 0 otherwise.
// Optional feature macro: PLL_CLK_EN_GEN_TOGGLE_EN (builds the toggle flop for clk_out).
module clk_en_div #(
    parameter int CNT_W = 16
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             run,      // channel will be in LOCKED next cycle
    input  logic             restart,  // phase origin: counter restarts at 0 next cycle
    input  logic [CNT_W-1:0] div,      // effective divide ratio (new value on a reload)
    output logic             ce,
    output logic             clk_out
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ce_nxt;

    // Next counter value and terminal-count pulse; div=0 parks the channel at 0
    always_comb begin
        cnt_nxt = '0;
        ce_nxt  = 1'b0;
        if (run && (div != '0)) begin
            if (restart || (cnt == div - ONE)) begin
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + ONE;
            end
            ce_nxt = (cnt_nxt == div - ONE);
        end
    end

    // Counter and enable registers
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            ce  <= ce_nxt;
        end
    end

`ifdef PLL_CLK_EN_GEN_TOGGLE_EN
    logic tog;

    // Square output: toggles on each enable pulse, restarts low on lock entry / reload
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            tog <= 1'b0;
        end else if (!run) begin
            tog <= 1'b0;
        end else if (restart) begin
            tog <= ce_nxt;
        end else begin
            tog <= tog ^ ce_nxt;
        end
    end

    assign clk_out = tog;
`else
    assign clk_out = 1'b0;
`endif

endmodule

// File: rtl/pll_clk_en_gen.sv
// Qualifies PLL lock and derives NUM_CH phase-aligned, programmable clock-enable trains.
// Latency: locked_q rises 2+LOCK_CYCLES cycles after pll_locked; loss seen within 3 cycles.
// Backpressure: none; div_load is a single-cycle strobe accepted in any state.
// Optional feature macro: PLL_CLK_EN_GEN_TOGGLE_EN (clk_out square outputs; tied low otherwise).
module pll_clk_en_gen
    import pll_clk_pkg::*;
#(
    parameter int                        NUM_CH      = 2,
    parameter int                        CNT_W       = 16,
    parameter int                        LOCK_CYCLES = 1024,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_RST     = {NUM_CH{16'd48}}
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH*CNT_W-1:0] div_i,
    input  logic                    div_load,
    output logic                    locked_q,
    output logic [NUM_CH-1:0]       ce,
    output logic [NUM_CH-1:0]       clk_out
);

    localparam int               LCW       = lock_cnt_w(LOCK_CYCLES);
    localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_CYCLES - 1);

    logic [1:0]              sync_q;
    logic                    lk_s;
    lock_state_e             state;
    logic [LCW-1:0]          lock_cnt;
    logic                    lock_nxt;
    logic [NUM_CH*CNT_W-1:0] div_r;
    logic [NUM_CH*CNT_W-1:0] div_eff;
    logic                    restart;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign lk_s = sync_q[1];

    // Will the FSM be in LOCKED next cycle; the final qualifying sample completes the count
    always_comb begin
        lock_nxt = 1'b0;
        if (lk_s) begin
            case (state)
                UNLOCKED: lock_nxt = (LOCK_CYCLES == 1);
                QUALIFY:  lock_nxt = (lock_cnt == LOCK_LAST);
                LOCKED:   lock_nxt = 1'b1;
                default:  lock_nxt = 1'b0;
            endcase
        end
    end

    // Lock FSM: qualify consecutive locked samples, drop immediately on loss
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UNLOCKED;
            lock_cnt <= '0;
            locked_q <= 1'b0;
        end else begin
            locked_q <= lock_nxt;
            case (state)
                UNLOCKED: begin
                    lock_cnt <= '0;
                    if (lk_s) begin
                        if (lock_nxt) begin
                            state <= LOCKED;
                        end else begin
                            state    <= QUALIFY;
                            lock_cnt <= LCW'(1);
                        end
                    end
                end
                QUALIFY: begin
                    if (!lk_s) begin
                        state    <= UNLOCKED;
                        lock_cnt <= '0;
                    end else if (lock_nxt) begin
                        state    <= LOCKED;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + LCW'(1);
                    end
                end
                LOCKED: begin
                    lock_cnt <= '0;
                    if (!lk_s) begin
                        state <= UNLOCKED;
                    end
                end
                default: begin
                    state    <= UNLOCKED;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    // Shadow divide ratios, captured on every strobe regardless of lock state
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= DIV_RST;
        end else if (div_load) begin
            div_r <= div_i;
        end
    end

    // A reload takes effect with its new ratios in the same edge that realigns the counters
    assign div_eff = div_load ? div_i : div_r;

    // Phase origin on lock entry and on any reload; all channels share it
    assign restart = !locked_q || div_load;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_en_div #(
            .CNT_W (CNT_W)
        ) u_ch (
            .refclk  (refclk),
            .rst_n   (rst_n),
            .run     (lock_nxt),
            .restart (restart),
            .div     (div_eff[k*CNT_W +: CNT_W]),
            .ce      (ce[k]),
            .clk_out (clk_out[k])
        );
    end

endmodule
